// File: rtl/rv32i_imem_responder.sv
// Instruction-memory responder: strobe/address in, one acked 32-bit word out after WAIT_STATES cycles.
// Define IMEM_ERR_EN to add o_err with alignment/range checking of requests and preload writes.
module rv32i_imem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_iaddr,
  input  logic        i_stb_inst,
  output logic        o_ack_inst,
  output logic [31:0] o_inst,
  output logic        o_busy,
  input  logic        i_abort,
  input  logic        i_we,
  input  logic [31:0] i_waddr,
  input  logic [31:0] i_wdata
`ifdef IMEM_ERR_EN
  ,
  output logic        o_err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, next_state;
  logic [3:0]              cnt, next_cnt;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    latch_req;
  logic                    load_resp;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [DEPTH_LOG2-1:0]   wr_idx;
  logic                    wr_ok;
  logic                    resp_err;
  logic [31:0]             mem [DEPTH];

  assign rd_idx = (state == WAIT) ? idx_q : i_iaddr[DEPTH_LOG2+1:2];
  assign wr_idx = i_waddr[DEPTH_LOG2+1:2];
  assign o_busy = (state == WAIT);

`ifdef IMEM_ERR_EN
  logic err_q;
  logic req_bad;
  logic unused_waddr;

  assign req_bad      = (i_iaddr[1:0] != 2'b00) || ((i_iaddr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign wr_ok        = ((i_waddr >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign resp_err     = (state == WAIT) ? err_q : req_bad;
  assign unused_waddr = ^i_waddr[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
      o_err <= 1'b0;
    end else begin
      if (latch_req) err_q <= req_bad;
      o_err <= load_resp & resp_err;
    end
  end
`else
  logic unused_addr;

  assign wr_ok       = 1'b1;
  assign resp_err    = 1'b0;
  assign unused_addr = ^{i_iaddr[31:DEPTH_LOG2+2], i_iaddr[1:0],
                         i_waddr[31:DEPTH_LOG2+2], i_waddr[1:0]};
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx_q <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (latch_req) idx_q <= i_iaddr[DEPTH_LOG2+1:2];
    end
  end

  // RESP accepts a new strobe just like IDLE, which gives 1 word/cycle at zero wait states.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    latch_req  = 1'b0;
    load_resp  = 1'b0;
    case (state)
      IDLE, RESP: begin
        next_state = IDLE;
        if (!i_abort && i_stb_inst) begin
          if (WAIT_STATES == 0) begin
            next_state = RESP;
            load_resp  = 1'b1;
          end else begin
            next_state = WAIT;
            next_cnt   = CNT_LOAD;
            latch_req  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (i_abort) begin
          next_state = IDLE;
        end else if (cnt == 4'd0) begin
          next_state = RESP;
          load_resp  = 1'b1;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_we && wr_ok) mem[wr_idx] <= i_wdata;
  end

  // A same-edge preload write is not seen here: the read samples the pre-edge RAM contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ack_inst <= 1'b0;
      o_inst     <= 32'd0;
    end else begin
      o_ack_inst <= load_resp;
      if (load_resp) o_inst <= resp_err ? NOP_WORD : mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_rv32i_imem_responder.sv
// Directed bench for rv32i_imem_responder: one instance with zero wait states, one with three.
// Define IMEM_ERR_EN to also exercise the error/NOP path.
module tb_rv32i_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        stb0 = 1'b0, abort0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, waddr0 = '0, wdata0 = '0;
  logic        ack0, busy0;
  logic [31:0] inst0;

  logic        stb3 = 1'b0, abort3 = 1'b0, we3 = 1'b0;
  logic [31:0] addr3 = '0, waddr3 = '0, wdata3 = '0;
  logic        ack3, busy3;
  logic [31:0] inst3;

`ifdef IMEM_ERR_EN
  logic        err0, err3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_imem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rst(rst), .i_iaddr(addr0), .i_stb_inst(stb0),
    .o_ack_inst(ack0), .o_inst(inst0), .o_busy(busy0), .i_abort(abort0),
    .i_we(we0), .i_waddr(waddr0), .i_wdata(wdata0)
`ifdef IMEM_ERR_EN
    , .o_err(err0)
`endif
  );

  rv32i_imem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
    .i_clk(clk), .i_rst(rst), .i_iaddr(addr3), .i_stb_inst(stb3),
    .o_ack_inst(ack3), .o_inst(inst3), .o_busy(busy3), .i_abort(abort3),
    .i_we(we3), .i_waddr(waddr3), .i_wdata(wdata3)
`ifdef IMEM_ERR_EN
    , .o_err(err3)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic applyStimulus(input logic sel3, input logic stb, input logic [31:0] addr, input logic abort);
    if (sel3) begin
      stb3 = stb; addr3 = addr; abort3 = abort;
    end else begin
      stb0 = stb; addr0 = addr; abort0 = abort;
    end
  endtask

  task automatic preload_word(input logic sel3, input logic [31:0] addr, input logic [31:0] data);
    if (sel3) begin
      we3 = 1'b1; waddr3 = addr; wdata3 = data;
    end else begin
      we0 = 1'b1; waddr0 = addr; wdata0 = data;
    end
    tick();
    we0 = 1'b0;
    we3 = 1'b0;
  endtask

  initial begin
    logic [31:0] seq_data [4];
    seq_data[0] = 32'h11; seq_data[1] = 32'h22; seq_data[2] = 32'h33; seq_data[3] = 32'h44;

    // Reset state
    tick();
    tick();
    checkOutput("rst_ack0",  32'(ack0),  32'd0);
    checkOutput("rst_inst0", inst0,      32'd0);
    checkOutput("rst_busy0", 32'(busy0), 32'd0);
    checkOutput("rst_ack3",  32'(ack3),  32'd0);
    checkOutput("rst_inst3", inst3,      32'd0);
    checkOutput("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) preload_word(1'b0, 32'(i * 4), seq_data[i]);
    preload_word(1'b0, 32'h14, 32'hAA);
    preload_word(1'b0, 32'hFFC, 32'hCAFEF00D);
    preload_word(1'b1, 32'h8, 32'hDEADBEEF);
    preload_word(1'b1, 32'h4, 32'h12345678);

    // Zero wait states: back-to-back acks with a continuously held strobe
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("b2b_ack%0d", i),  32'(ack0),  32'd1);
      checkOutput($sformatf("b2b_inst%0d", i), inst0,      seq_data[i]);
      checkOutput($sformatf("b2b_busy%0d", i), 32'(busy0), 32'd0);
      applyStimulus(1'b0, 1'b1, 32'((i + 1) * 4), 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("b2b_end_ack",  32'(ack0), 32'd0);
    checkOutput("b2b_hold_inst", inst0,    32'h44);

    // Abort and strobe on the same edge in IDLE: strobe is not taken
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("abort_stb_ack0", 32'(ack0), 32'd0);
    tick();
    checkOutput("abort_stb_ack0_late", 32'(ack0), 32'd0);

    // Three wait states: busy for 3 cycles, strobes during busy ignored
    applyStimulus(1'b1, 1'b1, 32'h8, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("ws3_busy%0d", c), 32'(busy3), 32'd1);
      checkOutput($sformatf("ws3_noack%0d", c), 32'(ack3), 32'd0);
      tick();
    end
    checkOutput("ws3_ack",  32'(ack3),  32'd1);
    checkOutput("ws3_inst", inst3,      32'hDEADBEEF);
    checkOutput("ws3_busy_resp", 32'(busy3), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("ws3_ack_drop", 32'(ack3), 32'd0);
    checkOutput("ws3_inst_hold", inst3,    32'hDEADBEEF);

    // Abort on the second wait cycle
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("abort_busy_before", 32'(busy3), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("abort_busy_after", 32'(busy3), 32'd0);
    checkOutput("abort_noack0", 32'(ack3), 32'd0);
    tick();
    checkOutput("abort_noack1", 32'(ack3), 32'd0);
    tick();
    checkOutput("abort_noack2", 32'(ack3), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h4, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("post_abort_wait%0d", c), 32'(ack3), 32'd0);
      tick();
    end
    checkOutput("post_abort_ack",  32'(ack3), 32'd1);
    checkOutput("post_abort_inst", inst3,     32'h12345678);
    tick();

    // Reset during WAIT discards the request; RAM survives
    applyStimulus(1'b1, 1'b1, 32'h8, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_ack",  32'(ack3),  32'd0);
    checkOutput("midrst_busy", 32'(busy3), 32'd0);
    checkOutput("midrst_inst", inst3,      32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("midrst_stray%0d", c), 32'(ack3), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 32'h8, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick(); tick(); tick();
    checkOutput("midrst_ram_ack",  32'(ack3), 32'd1);
    checkOutput("midrst_ram_inst", inst3,     32'hDEADBEEF);

    // Write and read of word 5 on the same edge returns the old data
    applyStimulus(1'b0, 1'b1, 32'h14, 1'b0);
    we0 = 1'b1; waddr0 = 32'h14; wdata0 = 32'h55;
    tick();
    we0 = 1'b0;
    checkOutput("rw_same_ack",  32'(ack0), 32'd1);
    checkOutput("rw_same_inst", inst0,     32'hAA);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rw_repeat_inst", inst0, 32'h55);
    tick();

`ifdef IMEM_ERR_EN
    // Misaligned / out-of-range request acks with NOP and o_err
    applyStimulus(1'b0, 1'b1, 32'h1002, 1'b0);
    tick();
    checkOutput("err_ack",  32'(ack0), 32'd1);
    checkOutput("err_inst", inst0,     32'h00000013);
    checkOutput("err_flag", 32'(err0), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'hFFC, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("top_ack",  32'(ack0), 32'd1);
    checkOutput("top_inst", inst0,     32'hCAFEF00D);
    checkOutput("top_err",  32'(err0), 32'd0);
    preload_word(1'b0, 32'h1000, 32'hBAD0BAD0);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("oob_write_dropped", inst0, 32'h11);
    checkOutput("oob_write_err",     32'(err0), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h9, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick(); tick(); tick();
    checkOutput("ws3_err_inst", inst3,      32'h00000013);
    checkOutput("ws3_err_flag", 32'(err3),  32'd1);
    tick();
    checkOutput("ws3_err_clear", 32'(err3), 32'd0);
`else
    // Upper address bits ignored: 0x1004 wraps to word 1, low bits dropped
    applyStimulus(1'b0, 1'b1, 32'h1004, 1'b0);
    tick();
    checkOutput("wrap_inst", inst0, 32'h22);
    applyStimulus(1'b0, 1'b1, 32'hFFF, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lowbits_inst", inst0, 32'hCAFEF00D);
    preload_word(1'b0, 32'h1010, 32'h77);
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_write_inst", inst0, 32'h77);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
